ahb_sram_ctrl: RTL and testbench

AHB-Lite responder that lets the system bus reach on-chip SRAM. It converts AHB-Lite transfers into a single-port synchronous SRAM interface: chip select, per-byte write enables, word address, write data and read data. The block sits between the AHB-Lite slave mux and the DFFRAM banks. It is the slave end of the bus that the NfiVe32 master drives.

---
 rtl/ahb_sram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite responder in front of a single-port synchronous SRAM.
// Reads are issued combinationally in the address phase, so SRAM data returns in
// the data phase with zero wait states. Writes are issued in the data phase.
// When a read follows a write, the two collide on the SRAM port and the read
// waits one cycle.
// Optional build macro AHB_SRAM_WBUF_EN: a one-entry posted write buffer
// removes that collision. Buffered data drains in free cycles and is
// forwarded to reads of the same word.
module ahb_sram_ctrl #(
   parameter int AW = 12
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic [31:0]   HADDR,
   input  logic [1:0]    HTRANS,
   input  logic          HWRITE,
   input  logic [2:0]    HSIZE,
   input  logic [31:0]   HWDATA,
   input  logic          HREADY,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [31:0]   HRDATA,
   input  logic [31:0]   SRAMRDATA,
   output logic          SRAMCS0,
   output logic [3:0]    SRAMWEN,
   output logic [31:0]   SRAMWDATA,
   output logic [AW-1:0] SRAMADDR
);

   typedef enum logic [2:0] {
      IDLE, RD_DATA, WR_DATA, WR_STALL, ERR1, ERR2
   } state_t;

   state_t        state;
   logic [AW-1:0] waddr;
   logic [1:0]    wsize;
   logic [1:0]    woff;
   logic [3:0]    wmask;

   logic          read_req;
   logic          accept;
   logic          size_err;
   logic          conflict;
   logic          hready_int;
   logic          rd_acc;
   logic          wr_acc;
   logic          err_acc;

   // HADDR bits above the word address and HTRANS[0] are intentionally ignored
   logic          unused_bits;
   assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

`ifdef AHB_SRAM_WBUF_EN
   logic          bvalid;
   logic [AW-1:0] baddr;
   logic [AW-1:0] raddr;
   logic [3:0]    bmask;
   logic [31:0]   bdata;
   logic          fwd;
`endif

   assign read_req = HSEL & HTRANS[1] & ~HWRITE;
   assign accept   = HSEL & HTRANS[1] & HREADY;
   assign size_err = (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

`ifdef AHB_SRAM_WBUF_EN
   // Only a full buffer blocks a read: it must drain before the new write lands
   assign conflict = (state == WR_DATA) & read_req & bvalid;
`else
   assign conflict = (state == WR_DATA) & read_req;
`endif

   assign hready_int = ~((state == ERR1) | conflict);
   assign rd_acc     = accept & hready_int & ~size_err & ~HWRITE & HRESETn;
   assign wr_acc     = accept & hready_int & ~size_err & HWRITE;
   assign err_acc    = accept & hready_int & size_err;

   // Transfer FSM and write address-phase capture
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= IDLE;
         waddr <= '0;
         wsize <= '0;
         woff  <= '0;
      end else begin
         if (state == ERR1)
            state <= ERR2;
         else if (conflict)
            state <= WR_STALL;
         else if (err_acc)
            state <= ERR1;
         else if (wr_acc)
            state <= WR_DATA;
         else if (rd_acc)
            state <= RD_DATA;
         else
            state <= IDLE;
         if (wr_acc) begin
            waddr <= HADDR[AW+1:2];
            wsize <= HSIZE[1:0];
            woff  <= HADDR[1:0];
         end
      end
   end

   // Byte-lane write enables from the captured size and offset
   always_comb begin
      wmask = 4'b1111;
      case (wsize)
         2'd0:    wmask = 4'b0001 << woff;
         2'd1:    wmask = woff[1] ? 4'b1100 : 4'b0011;
         default: wmask = 4'b1111;
      endcase
   end

`ifdef AHB_SRAM_WBUF_EN
   // Posted write buffer: loads at every write data phase, drains when the port is idle
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         bvalid <= 1'b0;
         baddr  <= '0;
         bmask  <= '0;
         bdata  <= '0;
         raddr  <= '0;
      end else begin
         if (state == WR_DATA) begin
            bvalid <= 1'b1;
            baddr  <= waddr;
            bmask  <= wmask;
            bdata  <= HWDATA;
         end else if (bvalid && !rd_acc) begin
            bvalid <= 1'b0;
         end
         if (rd_acc)
            raddr <= HADDR[AW+1:2];
      end
   end

   assign fwd = bvalid && (baddr == raddr);
`endif

   // Bus response: HRESP and HRDATA follow the registered state
   always_comb begin
      HREADYOUT = hready_int;
      HRESP     = (state == ERR1) || (state == ERR2);
      HRDATA    = '0;
      if (state == RD_DATA) begin
`ifdef AHB_SRAM_WBUF_EN
         for (int unsigned b = 0; b < 4; b++)
            HRDATA[8*b +: 8] = (fwd && bmask[b]) ? bdata[8*b +: 8] : SRAMRDATA[8*b +: 8];
`else
         HRDATA = SRAMRDATA;
`endif
      end
   end

   // SRAM port: address-phase read, or data-phase write (or buffer drain)
   always_comb begin
      SRAMCS0   = 1'b0;
      SRAMWEN   = '0;
      SRAMADDR  = '0;
      SRAMWDATA = '0;
      if (HRESETn) begin
`ifdef AHB_SRAM_WBUF_EN
         if (rd_acc) begin
            SRAMCS0  = 1'b1;
            SRAMADDR = HADDR[AW+1:2];
         end else if (bvalid) begin
            SRAMCS0   = 1'b1;
            SRAMWEN   = bmask;
            SRAMADDR  = baddr;
            SRAMWDATA = bdata;
         end
`else
         if (state == WR_DATA) begin
            SRAMCS0   = 1'b1;
            SRAMWEN   = wmask;
            SRAMADDR  = waddr;
            SRAMWDATA = HWDATA;
         end else if (rd_acc) begin
            SRAMCS0  = 1'b1;
            SRAMADDR = HADDR[AW+1:2];
         end
`endif
      end
   end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: pipelined AHB-Lite driver, behavioural SRAM, byte-lane
// reference memory and a read-data scoreboard for ahb_sram_ctrl.
module tb_ahb_sram_ctrl;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic [31:0] SRAMRDATA;
   logic        SRAMCS0;
   logic [3:0]  SRAMWEN;
   logic [31:0] SRAMWDATA;
   logic [11:0] SRAMADDR;

   int tests = 0;
   int fails = 0;

   // Single slave on the bus: bus ready is this slave's ready
   assign HREADY = HREADYOUT;

   ahb_sram_ctrl #(.AW(12)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .SRAMRDATA(SRAMRDATA), .SRAMCS0(SRAMCS0), .SRAMWEN(SRAMWEN),
      .SRAMWDATA(SRAMWDATA), .SRAMADDR(SRAMADDR)
   );

   always #5 HCLK = ~HCLK;

   // Behavioural synchronous SRAM (unwritten words read as zero)
   logic [31:0] mem [int];
   initial SRAMRDATA = '0;
   always @(posedge HCLK) begin
      if (SRAMCS0) begin
         for (int b = 0; b < 4; b++)
            if (SRAMWEN[b]) begin
               logic [31:0] t;
               t = mem.exists(int'(SRAMADDR)) ? mem[int'(SRAMADDR)] : 32'h0;
               t[8*b +: 8] = SRAMWDATA[8*b +: 8];
               mem[int'(SRAMADDR)] = t;
            end
         if (SRAMWEN == 4'b0000)
            SRAMRDATA <= mem.exists(int'(SRAMADDR)) ? mem[int'(SRAMADDR)] : 32'h0;
      end
   end

   // Reference memory seen from the bus, indexed by word address
   logic [31:0] model [int];
   logic [31:0] sb [$];

   // Pending transfer list
   bit          q_wr   [$];
   logic [31:0] q_addr [$];
   logic [2:0]  q_size [$];
   logic [31:0] q_data [$];

   function automatic bit is_err(input logic [2:0] s, input logic [31:0] a);
      return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] s, input logic [31:0] a);
      case (s)
         3'd0:    return 4'b0001 << a[1:0];
         3'd1:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_rd(input int w);
      return model.exists(w) ? model[w] : 32'h0;
   endfunction

   task automatic add(input bit w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      q_wr.push_back(w);
      q_addr.push_back(a);
      q_size.push_back(s);
      q_data.push_back(d);
   endtask

   task automatic drive_idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd0; HWDATA = '0;
   endtask

   task automatic idle_cycles(input int n);
      drive_idle();
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   // Runs the pending transfer list as a pipelined AHB sequence and checks
   // every data phase; exp_wait counts non-error wait cycles.
   task automatic run_seq(input string name, input int exp_wait);
      int n, ai, di, waits, cyc;
      bit dp_first, hr;
      logic [31:0] exp, ta;
      logic [3:0]  m;
      n = q_addr.size(); ai = 0; di = -1; waits = 0; cyc = 0; dp_first = 0;
      while ((ai < n || di >= 0) && cyc < 200) begin
         if (ai < n) begin
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = q_wr[ai]; HADDR = q_addr[ai]; HSIZE = q_size[ai];
         end else begin
            HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd0;
         end
         HWDATA = (di >= 0 && q_wr[di]) ? q_data[di] : 32'h0;
         @(negedge HCLK);
         hr = HREADYOUT;
         if (di >= 0) begin
            if (is_err(q_size[di], q_addr[di])) begin
               tests++;
               if (dp_first && (hr !== 1'b0 || HRESP !== 1'b1 || SRAMCS0 !== 1'b0)) begin
                  fails++;
                  $display("FAIL %s err1: ready=%b resp=%b cs=%b, want ready=0 resp=1 cs=0", name, hr, HRESP, SRAMCS0);
               end else if (!dp_first && (hr !== 1'b1 || HRESP !== 1'b1)) begin
                  fails++;
                  $display("FAIL %s err2: ready=%b resp=%b, want ready=1 resp=1", name, hr, HRESP);
               end
            end else begin
               if (!hr) waits++;
               tests++;
               if (HRESP !== 1'b0) begin
                  fails++;
                  $display("FAIL %s okay_resp: got %b want 0", name, HRESP);
               end
               if (hr && !q_wr[di]) begin
                  tests++;
                  if (sb.size() == 0) begin
                     fails++;
                     $display("FAIL %s scoreboard: read data %h with no expected entry", name, HRDATA);
                  end else begin
                     exp = sb.pop_front();
                     if (HRDATA !== exp) begin
                        fails++;
                        $display("FAIL %s rdata @%h: got %h want %h", name, q_addr[di], HRDATA, exp);
                     end
                  end
               end
`ifndef AHB_SRAM_WBUF_EN
               if (q_wr[di] && dp_first) begin
                  ta = q_addr[di];
                  m  = lane_mask(q_size[di], ta);
                  tests++;
                  if (SRAMCS0 !== 1'b1 || SRAMWEN !== m || SRAMADDR !== ta[13:2] || SRAMWDATA !== q_data[di]) begin
                     fails++;
                     $display("FAIL %s sram_write: cs=%b wen=%b addr=%h wdata=%h, want cs=1 wen=%b addr=%h wdata=%h",
                              name, SRAMCS0, SRAMWEN, SRAMADDR, SRAMWDATA, m, ta[13:2], q_data[di]);
                  end
               end
`endif
            end
         end
`ifndef AHB_SRAM_WBUF_EN
         if (ai < n && is_err(q_size[ai], q_addr[ai]) && !(di >= 0 && q_wr[di])) begin
            tests++;
            if (SRAMCS0 !== 1'b0) begin
               fails++;
               $display("FAIL %s err_addr_cs: got %b want 0", name, SRAMCS0);
            end
         end
`endif
         @(posedge HCLK);
         #1;
         cyc++;
         if (hr) begin
            if (ai < n) begin
               ta = q_addr[ai];
               if (!is_err(q_size[ai], ta)) begin
                  if (q_wr[ai]) begin
                     exp = model_rd(int'(ta[13:2]));
                     m   = lane_mask(q_size[ai], ta);
                     for (int b = 0; b < 4; b++)
                        if (m[b]) exp[8*b +: 8] = q_data[ai][8*b +: 8];
                     model[int'(ta[13:2])] = exp;
                  end else begin
                     sb.push_back(model_rd(int'(ta[13:2])));
                  end
               end
               di = ai;
               ai++;
            end else begin
               di = -1;
            end
            dp_first = 1'b1;
         end else begin
            dp_first = 1'b0;
         end
      end
      tests++;
      if (cyc >= 200) begin
         fails++;
         $display("FAIL %s timeout: %0d cycles, sequence incomplete", name, cyc);
      end
      tests++;
      if (waits != exp_wait) begin
         fails++;
         $display("FAIL %s wait_states: got %0d want %0d", name, waits, exp_wait);
      end
      q_wr.delete(); q_addr.delete(); q_size.delete(); q_data.delete(); sb.delete();
      idle_cycles(4);
   endtask

   task automatic check_reset_outputs(input string name);
      tests++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0 || SRAMCS0 !== 1'b0 ||
          SRAMWEN !== 4'h0 || SRAMADDR !== 12'h0 || SRAMWDATA !== 32'h0) begin
         fails++;
         $display("FAIL %s: ready=%b resp=%b rdata=%h cs=%b wen=%b addr=%h wdata=%h, want 1 0 0 0 0 0 0",
                  name, HREADYOUT, HRESP, HRDATA, SRAMCS0, SRAMWEN, SRAMADDR, SRAMWDATA);
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      drive_idle();
      #2;
      check_reset_outputs("reset_idle");
      // A selected read during reset must not reach the SRAM
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0100; HSIZE = 3'd2;
      #1;
      check_reset_outputs("reset_with_read");
      @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      drive_idle();
      @(posedge HCLK); #1;
      for (int t = 0; t < 2; t++) begin
         HSEL = 1'b1; HTRANS = (t == 0) ? 2'b00 : 2'b01; HADDR = 32'h0000_0104; HSIZE = 3'd2;
         @(negedge HCLK);
         tests++;
         if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || SRAMCS0 !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy[%0d]: ready=%b resp=%b cs=%b, want 1 0 0", t, HREADYOUT, HRESP, SRAMCS0);
         end
         @(posedge HCLK); #1;
      end
      idle_cycles(2);
   endtask

   task automatic test_word_rw();
      add(1, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF);
      add(0, 32'h0000_0100, 3'd2, 32'h0);
`ifdef AHB_SRAM_WBUF_EN
      run_seq("word_rw", 0);
`else
      run_seq("word_rw", 1);
`endif
   endtask

   task automatic test_byte_half();
      add(1, 32'h0000_0101, 3'd0, 32'h0000_AB00);
      add(0, 32'h0000_0100, 3'd2, 32'h0);
      add(1, 32'h0000_0106, 3'd1, 32'hCAFE_0000);
      add(0, 32'h0000_0104, 3'd2, 32'h0);
`ifdef AHB_SRAM_WBUF_EN
      run_seq("byte_half", 0);
`else
      run_seq("byte_half", 2);
`endif
      tests++;
      if (model_rd(32'h40) !== 32'hDEAD_ABEF) begin
         fails++;
         $display("FAIL byte_merge_ref: got %h want deadabef", model_rd(32'h40));
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         add(1, 32'h0000_0500 + 32'(4*i), 3'd2, 32'hA5A5_0000 + 32'(i * 32'h1111));
      for (int i = 0; i < 4; i++)
         add(0, 32'h0000_0500 + 32'(4*i), 3'd2, 32'h0);
      run_seq("back_to_back", 1);
   endtask

   task automatic test_errors();
      add(0, 32'h0000_0200, 3'd3, 32'h0);
      add(0, 32'h0000_0201, 3'd1, 32'h0);
      add(1, 32'h0000_0202, 3'd2, 32'h0);
      add(0, 32'h0000_0100, 3'd2, 32'h0);
      run_seq("errors", 0);
   endtask

   task automatic test_reset_mid_write();
      add(1, 32'h0000_0400, 3'd2, 32'h55AA_55AA);
      run_seq("pre_reset_write", 0);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0400; HSIZE = 3'd2;
      @(posedge HCLK); #1;
      drive_idle();
      HWDATA = 32'h1111_1111;
      #1;
`ifndef AHB_SRAM_WBUF_EN
      tests++;
      if (SRAMCS0 !== 1'b1 || SRAMWEN !== 4'hF) begin
         fails++;
         $display("FAIL mid_write_active: cs=%b wen=%b, want 1 1111", SRAMCS0, SRAMWEN);
      end
`endif
      HRESETn = 1'b0;
      #1;
      check_reset_outputs("reset_mid_write");
      @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      idle_cycles(3);
      tests++;
      if (!mem.exists(32'h100) || mem[32'h100] !== 32'h55AA_55AA) begin
         fails++;
         $display("FAIL reset_sram_word: got %h want 55aa55aa", mem.exists(32'h100) ? mem[32'h100] : 32'h0);
      end
      add(0, 32'h0000_0400, 3'd2, 32'h0);
      run_seq("read_after_reset", 0);
   endtask

   task automatic test_wbuf_forward();
      add(1, 32'h0000_0300, 3'd2, 32'h1234_5678);
      add(0, 32'h0000_0300, 3'd2, 32'h0);
`ifdef AHB_SRAM_WBUF_EN
      run_seq("wbuf_forward", 0);
`else
      run_seq("wbuf_forward", 1);
`endif
      tests++;
      if (!mem.exists(32'hC0) || mem[32'hC0] !== 32'h1234_5678) begin
         fails++;
         $display("FAIL sram_word_0x300: got %h want 12345678", mem.exists(32'hC0) ? mem[32'hC0] : 32'h0);
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_half();
      test_back_to_back();
      test_errors();
      test_reset_mid_write();
      test_wbuf_forward();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
